// File: rtl/product_acc_pkg.sv
// rtl/product_acc_pkg.sv - shared widths, state encoding and length decode for product_accumulator
package product_acc_pkg;

  localparam int ACC_W_DEF  = 16;
  localparam int PROD_W_DEF = 8;
  localparam int LEN_W      = 4;

  typedef enum logic [1:0] {
    ACC      = 2'd0,
    DRAIN_LO = 2'd1,
    DRAIN_HI = 2'd2
  } acc_state_t;

  // A len field of zero encodes the full 16-sample batch.
  function automatic logic [LEN_W:0] batch_len(input logic [LEN_W-1:0] l);
    return (l == '0) ? (LEN_W+1)'(1 << LEN_W) : {1'b0, l};
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product input, batch control and byte output bundle
interface product_accumulator_if
  import product_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF
);
  logic              in_valid;
  logic [PROD_W-1:0] in_product;
  logic              in_ready;
  logic [LEN_W-1:0]  len;
  logic              clr;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  logic [LEN_W-1:0]  count;

  modport master (
    output in_valid, in_product, len, clr, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_product, len, clr, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums a batch of products, then emits the total low byte then high byte
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int PROD_W = PROD_W_DEF
) (
  input logic                  clk,
  input logic                  rst,
  product_accumulator_if.slave bus
);

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W:0]   cnt;
  logic [LEN_W:0]   len_q;
  logic [LEN_W:0]   target;
  logic [LEN_W:0]   cnt_next;
  logic             accept;

  assign bus.in_ready  = (state == ACC) && !bus.clr;
  assign bus.out_valid = (state != ACC);
  assign bus.out_data  = (state == DRAIN_HI) ? acc[15:8] : acc[7:0];
  assign bus.count     = cnt[LEN_W-1:0];

  assign accept   = bus.in_valid && bus.in_ready;
  assign cnt_next = cnt + (LEN_W+1)'(1);
  // The first accept of a batch closes against the len being latched on that same edge.
  assign target   = (cnt == '0) ? batch_len(bus.len) : len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      len_q <= batch_len(4'd0);
    end else if (bus.clr) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        ACC: begin
          if (accept) begin
            acc <= acc + ACC_W'(bus.in_product);
            cnt <= cnt_next;
            if (cnt == '0) len_q <= batch_len(bus.len);
            if (cnt_next == target) state <= DRAIN_LO;
          end
        end
        DRAIN_LO: begin
          if (bus.out_ready) state <= DRAIN_HI;
        end
        DRAIN_HI: begin
          if (bus.out_ready) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed and randomized batches checked against an arithmetic model
module tb_product_accumulator;
  import product_acc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  product_accumulator_if #(.PROD_W(8)) bus ();

  product_accumulator #(.ACC_W(16), .PROD_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycles in ACC with nothing offered; the batch count must not move.
  task automatic idle(input int k, input int exp_cnt);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      bus.in_valid   = 1'b0;
      bus.in_product = 8'($urandom);
      bus.out_ready  = 1'($urandom_range(0, 1));
      #1;
      chk("idle_in_ready", bus.in_ready, 1);
      chk("idle_out_valid", bus.out_valid, 0);
      chk("idle_count", bus.count, exp_cnt);
    end
  endtask

  // Offers n products; len is presented on the first one and replaced by late_len (or junk) afterwards.
  task automatic feed(input int l, input int n, input int p0, input int p1, input bit rnd,
                      input int late_len, output int sum);
    int p;
    sum = 0;
    for (int i = 0; i < n; i++) begin
      if (rnd) idle($urandom_range(0, 2), i);
      p = rnd ? int'($urandom_range(0, 225)) : ((i == 0) ? p0 : p1);
      @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.in_product = 8'(p);
      bus.len        = (i == 0) ? 4'(l) : ((late_len < 0) ? 4'($urandom) : 4'(late_len));
      bus.out_ready  = 1'($urandom_range(0, 1));
      #1;
      chk("acc_in_ready", bus.in_ready, 1);
      chk("acc_out_valid", bus.out_valid, 0);
      chk("acc_count", bus.count, i);
      sum += p;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Expects the low byte then the high byte of sum, each held through `stall` not-ready cycles.
  task automatic drain(input int sum, input int n, input int stall);
    int k;
    int exp_b;
    for (int b = 0; b < 2; b++) begin
      exp_b = (b == 0) ? (sum % 256) : ((sum / 256) % 256);
      k = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
      for (int s = 0; s <= k; s++) begin
        bus.out_ready  = (s == k);
        bus.in_valid   = 1'($urandom_range(0, 1));
        bus.in_product = 8'($urandom);
        #1;
        chk(b == 0 ? "lo_valid" : "hi_valid", bus.out_valid, 1);
        chk(b == 0 ? "lo_data" : "hi_data", bus.out_data, exp_b);
        chk("drain_in_ready", bus.in_ready, 0);
        chk("drain_count", bus.count, n % 16);
        @(negedge clk);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'($urandom_range(0, 1));
    #1;
    chk("post_out_valid", bus.out_valid, 0);
    chk("post_in_ready", bus.in_ready, 1);
    chk("post_count", bus.count, 0);
  endtask

  initial begin
    int s;
    int l;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.len        = '0;
    bus.clr        = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_count", bus.count, 0);
    idle(2, 0);

    feed(3, 3, 225, 225, 1'b0, -1, s);
    drain(s, 3, 0);
    feed(0, 16, 225, 225, 1'b0, -1, s);
    drain(s, 16, 0);
    feed(2, 2, 10, 20, 1'b0, -1, s);
    drain(s, 2, 5);

    // clr together with an offered product: nothing is taken and the partial batch is dropped.
    feed(4, 2, 9, 9, 1'b0, 4, s);
    bus.clr        = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_product = 8'd50;
    #1;
    chk("clr_in_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.clr      = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("clr_count", bus.count, 0);
    chk("clr_out_valid", bus.out_valid, 0);
    chk("clr_out_data", bus.out_data, 0);
    feed(4, 4, 1, 1, 1'b0, -1, s);
    drain(s, 4, 0);

    // clr during drain abandons the pending bytes.
    feed(3, 3, 0, 0, 1'b1, -1, s);
    bus.clr       = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("clrd_out_valid", bus.out_valid, 1);
    @(negedge clk);
    bus.clr = 1'b0;
    #1;
    chk("clrd_post_valid", bus.out_valid, 0);
    chk("clrd_post_ready", bus.in_ready, 1);
    chk("clrd_post_count", bus.count, 0);

    // rst while the high byte is pending.
    feed(3, 3, 200, 150, 1'b0, -1, s);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    #1;
    chk("rsthi_data", bus.out_data, s / 256);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rsthi_out_valid", bus.out_valid, 0);
    chk("rsthi_in_ready", bus.in_ready, 1);
    chk("rsthi_count", bus.count, 0);
    chk("rsthi_out_data", bus.out_data, 0);
    feed(1, 1, 7, 7, 1'b0, -1, s);
    drain(s, 1, -1);

    feed(2, 2, 0, 0, 1'b1, 5, s);
    drain(s, 2, -1);

    for (int t = 0; t < 20; t++) begin
      l = int'($urandom_range(0, 15));
      feed(l, (l == 0) ? 16 : l, 0, 0, 1'b1, -1, s);
      drain(s, (l == 0) ? 16 : l, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter: ACC_W, 16, accumulator/result width in bits.
REQ-002 SHALL have parameter: PROD_W, 8, width of incoming product.
REQ-003 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: in_valid  input  1  product word offered.
REQ-006 SHALL have port: in_product  input  PROD_W  unsigned product from the 4x4 multiplier stage.
REQ-007 SHALL have port: in_ready  output  1  block accepts product this cycle.
REQ-008 SHALL have port: len  input  4  batch length; 1..15 literal, 0 means 16.
REQ-009 SHALL have port: clr  input  1  synchronous abort/clear of current batch.
REQ-010 SHALL have port: out_valid  output  1  result byte presented.
REQ-011 SHALL have port: out_data  output  8  result byte, low byte first then high byte.
REQ-012 SHALL have port: out_ready  input  1  downstream takes byte.
REQ-013 SHALL have port: count  output  4  samples accepted in current batch.

Function
REQ-014 SHALL implement FSM states ACC, DRAIN_LO, DRAIN_HI.
REQ-015 In ACC: in_ready = ~clr, out_valid = 0; in DRAIN_LO/DRAIN_HI: in_ready = 0, out_valid = 1.
REQ-016 Accept = in_valid & in_ready; on accept, acc <= acc + zero-extended in_product and count <= count + 1 (registered, visible next cycle).
REQ-017 len SHALL be latched into batch length register on the accept where count == 0; len changes mid-batch have no effect.
REQ-018 When the accept brings count to the latched length, next state SHALL be DRAIN_LO; out_valid asserts the following cycle (1-cycle latency from final accept).
REQ-019 DRAIN_LO: out_data = acc[7:0]; on out_valid & out_ready -> DRAIN_HI.
REQ-020 DRAIN_HI: out_data = acc[15:8]; on out_valid & out_ready -> ACC with acc <= 0, count <= 0 in same edge.
REQ-021 out_data and out_valid SHALL remain stable while out_ready is low (no byte dropped or repeated).
REQ-022 Maximum sum 16 x 225 = 3600; accumulator SHALL never wrap; bits above bit 11 read 0 for legal inputs.
REQ-023 clr high in any state SHALL, next edge, force ACC, acc <= 0, count <= 0; clr overrides accept and drain handshake.
REQ-024 clr and in_valid high together: sample SHALL NOT be accepted (in_ready is 0).
REQ-025 in ACC with out_ready high and no data: no state change.

Reset
REQ-026 On rst high at a clock edge: state ACC, acc = 0, count = 0, latched length = 16; outputs next cycle: in_ready = 1, out_valid = 0, out_data = 0, count = 0.
REQ-027 rst SHALL take priority over clr and all handshakes, including mid-drain.

Structure
REQ-028 State encodings (ACC=0, DRAIN_LO=1, DRAIN_HI=2) and the default widths SHALL live in shared package product_acc_pkg.
REQ-029 Single module, no sub-module; one FSM, one accumulator register, one counter, one length register.
REQ-030 out_data SHALL be a mux of the accumulator bytes selected by state (no extra output register).

Verification
REQ-031 len=3, products 225,225,225 back-to-back, out_ready=1 -> bytes 0xA3 then 0x02; count returns 0.
REQ-032 len=0, sixteen products of 225 -> bytes 0x10 then 0x0E (3600), out_valid one cycle after 16th accept.
REQ-033 len=2, products 10,20, out_ready low 5 cycles -> out_data held 0x1E with out_valid=1, in_ready=0, then 0x1E, 0x00.
REQ-034 len=4, accept 2 samples, pulse clr together with in_valid=1, product 50 -> count=0, 50 not accumulated; next batch 1,1,1,1 yields 0x04, 0x00.
REQ-035 rst asserted during DRAIN_HI -> next cycle out_valid=0, in_ready=1, count=0; subsequent len=1, product 7 yields 0x07, 0x00.
REQ-036 len changed from 2 to 5 after first accept -> batch still closes after 2 samples.
